// File: rtl/mem_timer_pkg.sv
// mem_timer_pkg: shared definitions for the memory-mapped timer.
//   - bus widths matching the CPU data-memory port
//   - word offsets decoded from addr[4:2]
//   - CTRL bit positions and the packed CTRL register layout
package mem_timer_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  // Word offsets (addr[4:2]); 5..7 are unmapped and read as zero.
  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_COUNT    = 3'd1;
  localparam logic [2:0] TMR_COMPARE  = 3'd2;
  localparam logic [2:0] TMR_STATUS   = 3'd3;
  localparam logic [2:0] TMR_PRESCALE = 3'd4;

  // CTRL bit positions.
  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IE         = 2;

  // Field order puts en at bit 0, matching the CTRL_* indices above.
  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } tmr_ctrl_t;

endpackage

// File: rtl/mem_timer_prescaler.sv
// mem_timer_prescaler: divides clk into timer ticks.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   run        - CTRL.EN; the counter holds while low
//   clr        - a PRESCALE register write; zeroes the counter
//   prescale   - terminal count; tick every (prescale+1) enabled cycles
//   tick       - high for the cycle in which the counter sits at prescale
module mem_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && (cnt_q == prescale);
    cnt_d = cnt_q;
    if (run) cnt_d = tick ? '0 : cnt_q + 1'b1;
    // A new divisor always restarts the division from zero.
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_timer.sv
// mem_timer: timer/counter slave on the CPU data-memory port.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - slave select (address decoded externally)
//   write_en        - write strobe, qualified by en
//   write_sel[3:0]  - byte enables for write_data
//   addr[31:0]      - byte address; only addr[4:2] is decoded
//   write_data[31:0]- write data
//   read_data[31:0] - combinational read data, zero unless en & ~write_en
//   timer_int       - level interrupt, MATCH & CTRL.IE
module mem_timer
  import mem_timer_pkg::*;
#(
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                write_en,
  input  logic [3:0]          write_sel,
  input  logic [ADDR_BUS-1:0] addr,
  input  logic [DATA_BUS-1:0] write_data,
  output logic [DATA_BUS-1:0] read_data,
  output logic                timer_int
);

  tmr_ctrl_t             ctrl_q, ctrl_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic [2:0]  reg_sel;
  logic        wr;
  logic        tick;
  logic        hit;
  logic        pre_clr;
  logic [31:0] count_tick;

  // Only addr[4:2] selects a register; the rest is decoded upstream.
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_BUS-1:5], addr[1:0]};

  assign reg_sel = addr[4:2];
  assign wr      = en && write_en;
  assign pre_clr = wr && (reg_sel == TMR_PRESCALE) && (write_sel != 4'b0000);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  mem_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (ctrl_q.en),
    .clr      (pre_clr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    // Counter value the tick alone would produce.
    hit        = tick && (count_q == compare_q);
    count_tick = count_q;
    if (tick) count_tick = (hit && ctrl_q.autoreload) ? 32'd0 : count_q + 32'd1;

    ctrl_d     = ctrl_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    match_d    = match_q;
    // Written lanes override the tick result; unwritten lanes keep it.
    count_d    = count_tick;

    if (wr) begin
      unique case (reg_sel)
        TMR_CTRL: if (write_sel[0]) begin
          ctrl_d.en         = write_data[CTRL_EN];
          ctrl_d.autoreload = write_data[CTRL_AUTORELOAD];
          ctrl_d.ie         = write_data[CTRL_IE];
        end
        TMR_COUNT:   count_d   = byte_merge(count_tick, write_data, write_sel);
        TMR_COMPARE: compare_d = byte_merge(compare_q, write_data, write_sel);
        TMR_STATUS:  if (write_sel[0] && write_data[0]) match_d = 1'b0;
        TMR_PRESCALE: begin
          for (int i = 0; i < PRESCALE_W; i++)
            if (write_sel[i/8]) prescale_d[i] = write_data[i];
        end
        default: ;
      endcase
    end

    // A new match wins over a same-cycle software clear.
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      match_q    <= 1'b0;
      prescale_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
    end
  end

  // Purely from flops, so no bus-to-interrupt combinational path.
  assign timer_int = match_q && ctrl_q.ie;

  always_comb begin
    read_data = '0;
    if (en && !write_en) begin
      unique case (reg_sel)
        TMR_CTRL:     read_data = 32'(ctrl_q);
        TMR_COUNT:    read_data = count_q;
        TMR_COMPARE:  read_data = compare_q;
        TMR_STATUS:   read_data = {31'd0, match_q};
        TMR_PRESCALE: read_data = 32'(prescale_q);
        default:      read_data = '0;
      endcase
    end
  end

endmodule
